// File: rtl/bcd_clock_ctrl.sv
// bcd_clock_ctrl: BCD time-of-day counter with a prescaler, run-time
// 12/24-hour display formatting, a validated time-load port and an optional
// minute-resolution alarm.
//
// Time is always kept in 24-hour BCD; mode24 only changes the hh/pm view.
// Optional feature macro: BCD_CLOCK_ALARM_EN builds the alarm registers,
// comparator and alarm pulse. Without it, alarm is tied low and the alarm
// inputs are ignored (the ports stay).
module bcd_clock_ctrl #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       mode24,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_err,
  input  logic       alarm_set,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_on,
  output logic       alarm,
  output logic       tick,
  output logic       pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
);

  localparam logic [23:0] PC_LAST = 24'(TICK_DIV - 1);

  logic [7:0]  h24, m, s;
  logic [23:0] pc;

  logic        adv;
  logic        load_ok;
  logic        load_acc;
  logic [7:0]  h_nx, m_nx, s_nx;
  logic        s_carry, m_carry;
  logic [7:0]  s_inc, m_inc, h_inc;

  // BCD increment with wrap at 'last'; returns {carry, next value}.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)           return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // True when both nibbles are decimal digits and the value is <= max.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // Next-state for the time registers: second advance, carries and load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    h_nx    = h24;
    m_nx    = m;
    s_nx    = s;
    adv     = ena && (pc == PC_LAST);
    load_ok = bcd_ok(load_hh, 8'h23) && bcd_ok(load_mm, 8'h59) && bcd_ok(load_ss, 8'h59);
    load_acc = load && load_ok;
    {s_carry, s_inc} = bcd_inc(s, 8'h59);
    {m_carry, m_inc} = bcd_inc(m, 8'h59);
    h_inc   = bcd_inc(h24, 8'h23)[7:0];
    if (load_acc) begin
      h_nx = load_hh;
      m_nx = load_mm;
      s_nx = load_ss;
    end else if (adv) begin
      s_nx = s_inc;
      if (s_carry) begin
        m_nx = m_inc;
        if (m_carry) h_nx = h_inc;
      end
    end
  end

  // Time, prescaler and the tick/load_err status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h24      <= 8'h00;
      m        <= 8'h00;
      s        <= 8'h00;
      pc       <= 24'd0;
      tick     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others.
      h24      <= h_nx;
      m        <= m_nx;
      s        <= s_nx;
      tick     <= adv && !load_acc;
      load_err <= load && !load_ok;
      if (load_acc)  pc <= 24'd0;
      else if (adv)  pc <= 24'd0;
      else if (ena)  pc <= pc + 24'd1;
    end
  end

`ifdef BCD_CLOCK_ALARM_EN
  logic [7:0] al_hh, al_mm;

  // Alarm registers and the pulse on an advance that lands on hh:mm:00.
  // The compare sees the pre-edge alarm registers, so a same-cycle
  // alarm_set only affects later advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      al_hh <= 8'h00;
      al_mm <= 8'h00;
      alarm <= 1'b0;
    end else begin
      if (alarm_set) begin
        al_hh <= alarm_hh;
        al_mm <= alarm_mm;
      end
      alarm <= alarm_on && adv && !load_acc &&
               (h_nx == al_hh) && (m_nx == al_mm) && (s_nx == 8'h00);
    end
  end
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_set, alarm_hh, alarm_mm, alarm_on};
  assign alarm = 1'b0;
`endif

  // Display formatting: 24-hour passthrough or 12-hour mapping of h24.
  always_comb begin
    hh = h24;
    mm = m;
    ss = s;
    pm = (h24 >= 8'h12);
    if (!mode24) begin
      unique case (h24)
        8'h00:   hh = 8'h12;
        8'h13:   hh = 8'h01;
        8'h14:   hh = 8'h02;
        8'h15:   hh = 8'h03;
        8'h16:   hh = 8'h04;
        8'h17:   hh = 8'h05;
        8'h18:   hh = 8'h06;
        8'h19:   hh = 8'h07;
        8'h20:   hh = 8'h08;
        8'h21:   hh = 8'h09;
        8'h22:   hh = 8'h10;
        8'h23:   hh = 8'h11;
        default: hh = h24;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_clock_ctrl.sv
// Directed bench for bcd_clock_ctrl: one instance with TICK_DIV=1 (u1) and
// one with TICK_DIV=4 (u4) sharing all inputs. Expected values are
// hand-computed. Alarm expectations follow BCD_CLOCK_ALARM_EN.
module tb_bcd_clock_ctrl;

`ifdef BCD_CLOCK_ALARM_EN
  localparam logic ALARM_EXP = 1'b1;
`else
  localparam logic ALARM_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, ena, mode24, load, alarm_set, alarm_on;
  logic [7:0] load_hh, load_mm, load_ss, alarm_hh, alarm_mm;

  logic       load_err1, alarm1, tick1, pm1;
  logic [7:0] hh1, mm1, ss1;
  logic       load_err4, alarm4, tick4, pm4;
  logic [7:0] hh4, mm4, ss4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_clock_ctrl #(.TICK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24),
    .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .load_err(load_err1), .alarm_set(alarm_set), .alarm_hh(alarm_hh),
    .alarm_mm(alarm_mm), .alarm_on(alarm_on), .alarm(alarm1),
    .tick(tick1), .pm(pm1), .hh(hh1), .mm(mm1), .ss(ss1)
  );

  bcd_clock_ctrl #(.TICK_DIV(4)) u4 (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24),
    .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .load_err(load_err4), .alarm_set(alarm_set), .alarm_hh(alarm_hh),
    .alarm_mm(alarm_mm), .alarm_on(alarm_on), .alarm(alarm4),
    .tick(tick4), .pm(pm4), .hh(hh4), .mm(mm4), .ss(ss4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] se);
    load = 1'b1; load_hh = h; load_mm = mi; load_ss = se;
  endtask

  initial begin
    reset = 1'b0; ena = 1'b0; mode24 = 1'b0; load = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
    alarm_set = 1'b0; alarm_hh = 8'h00; alarm_mm = 8'h00; alarm_on = 1'b0;

    // Reset values, 12-hour then 24-hour view.
    #12;
    check("rst_hh12", hh1, 8'h12);
    check("rst_mm",   mm1, 8'h00);
    check("rst_ss",   ss1, 8'h00);
    check("rst_pm",   pm1, 1'b0);
    check("rst_tick", tick1, 1'b0);
    check("rst_lerr", load_err1, 1'b0);
    check("rst_alarm", alarm1, 1'b0);
    mode24 = 1'b1; #1;
    check("rst_hh24", hh1, 8'h00);
    mode24 = 1'b0;
    cyc();
    reset = 1'b1;

    // Load 11:59:59 coincident with an advance: load wins, then noon.
    set_load(8'h11, 8'h59, 8'h59); ena = 1'b1;
    cyc();
    load = 1'b0;
    check("ld_hh", hh1, 8'h11);
    check("ld_ss", ss1, 8'h59);
    check("ld_tick", tick1, 1'b0);
    cyc();
    check("noon_hh", hh1, 8'h12);
    check("noon_mm", mm1, 8'h00);
    check("noon_ss", ss1, 8'h00);
    check("noon_pm", pm1, 1'b1);
    check("noon_tick", tick1, 1'b1);

    // Load 23:59:59 with ena low, then midnight.
    ena = 1'b0; set_load(8'h23, 8'h59, 8'h59);
    cyc();
    load = 1'b0;
    check("h23_hh12", hh1, 8'h11);
    check("h23_pm", pm1, 1'b1);
    check("h23_tick", tick1, 1'b0);
    ena = 1'b1;
    cyc();
    check("mid_hh12", hh1, 8'h12);
    check("mid_pm", pm1, 1'b0);
    check("mid_mm", mm1, 8'h00);
    check("mid_tick", tick1, 1'b1);
    mode24 = 1'b1; #1;
    check("mid_hh24", hh1, 8'h00);
    mode24 = 1'b0;

    // Prescaler with ena pattern 1,1,0,0,1,1 on TICK_DIV=4.
    ena = 1'b0; set_load(8'h00, 8'h00, 8'h00);
    cyc();
    load = 1'b0;
    begin
      logic [5:0] pat;
      pat = 6'b110011;
      for (int i = 0; i < 6; i++) begin
        ena = pat[5-i];
        cyc();
        check($sformatf("pre_ss%0d", i), ss4, (i == 5) ? 8'h01 : 8'h00);
        check($sformatf("pre_tick%0d", i), tick4, (i == 5) ? 1'b1 : 1'b0);
      end
    end
    ena = 1'b0;
    cyc();
    check("pre_tick_off", tick4, 1'b0);
    check("pre_ss_hold", ss4, 8'h01);

    // Load 08:30:15 on the cycle where u4 would advance.
    ena = 1'b1;
    repeat (3) cyc();
    check("pri_ss_before", ss4, 8'h01);
    set_load(8'h08, 8'h30, 8'h15);
    cyc();
    load = 1'b0;
    check("pri_hh", hh4, 8'h08);
    check("pri_mm", mm4, 8'h30);
    check("pri_ss", ss4, 8'h15);
    check("pri_tick", tick4, 1'b0);
    repeat (3) cyc();
    check("pri_pc_clr", ss4, 8'h15);
    cyc();
    check("pri_next_ss", ss4, 8'h16);
    check("pri_next_tick", tick4, 1'b1);
    check("u1_ss19", ss1, 8'h19);

    // Rejected loads leave the time alone.
    ena = 1'b0; set_load(8'h24, 8'h00, 8'h00);
    cyc();
    load = 1'b0;
    check("rej24_err", load_err4, 1'b1);
    check("rej24_hh", hh4, 8'h08);
    check("rej24_ss", ss4, 8'h16);
    cyc();
    check("rej_err_clr", load_err4, 1'b0);
    set_load(8'h12, 8'h5A, 8'h00);
    cyc();
    load = 1'b0;
    check("rej5A_err", load_err4, 1'b1);
    check("rej5A_mm", mm4, 8'h30);
    // Rejected load while counting: u1 still advances.
    ena = 1'b1; set_load(8'h09, 8'h60, 8'h00);
    cyc();
    load = 1'b0; ena = 1'b0;
    check("rejcnt_err", load_err1, 1'b1);
    check("rejcnt_ss", ss1, 8'h20);
    check("rejcnt_tick", tick1, 1'b1);

    // Alarm at 07:00, armed.
    alarm_set = 1'b1; alarm_hh = 8'h07; alarm_mm = 8'h00; alarm_on = 1'b1;
    cyc();
    alarm_set = 1'b0; alarm_hh = 8'h00;
    set_load(8'h06, 8'h59, 8'h58);
    cyc();
    load = 1'b0; ena = 1'b1;
    cyc();
    check("al_pre_ss", ss1, 8'h59);
    check("al_pre", alarm1, 1'b0);
    cyc();
    check("al_hh", hh1, 8'h07);
    check("al_fire", alarm1, ALARM_EXP);
    cyc();
    check("al_once", alarm1, 1'b0);
    check("al_u4_quiet", alarm4, 1'b0);
    // Disarmed: no pulse.
    ena = 1'b0; alarm_on = 1'b0; set_load(8'h06, 8'h59, 8'h59);
    cyc();
    load = 1'b0; ena = 1'b1;
    cyc();
    check("al_off_ss", ss1, 8'h00);
    check("al_off", alarm1, 1'b0);
    // A load that lands on the alarm time does not fire.
    ena = 1'b0; alarm_on = 1'b1; set_load(8'h07, 8'h00, 8'h00);
    cyc();
    load = 1'b0;
    check("al_load", alarm1, 1'b0);
    alarm_on = 1'b0;

    // Reset in the middle of a prescale count (pc = 2 of 4).
    set_load(8'h10, 8'h20, 8'h30);
    cyc();
    load = 1'b0; ena = 1'b1;
    repeat (2) cyc();
    ena = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("mr_hh", hh4, 8'h12);
    check("mr_mm", mm4, 8'h00);
    check("mr_ss", ss4, 8'h00);
    cyc();
    reset = 1'b1; ena = 1'b1;
    repeat (3) cyc();
    check("mr_ss3", ss4, 8'h00);
    check("mr_tick3", tick4, 1'b0);
    cyc();
    check("mr_ss4", ss4, 8'h01);
    check("mr_tick4", tick4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
